// File: rtl/dmem_arbiter_pkg.sv
// Shared data-memory types and defaults for the dmem port arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [MASK_W-1:0] dmem_mask_t;

  localparam dmem_mask_t  DMEM_MASK_NONE        = 4'b0000;
  localparam int unsigned DMEM_MAX_WAIT_DEFAULT = 4;

  // One memory-port access as presented to the macro.
  typedef struct packed {
    word_t      addr;
    word_t      wdata;
    dmem_mask_t mask;
  } dmem_req_t;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has priority, aux master is guaranteed
// a grant after MAX_WAIT consecutive denied cycles. Read owner is tracked 1 deep.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DMEM_MAX_WAIT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [WORD_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_write_data_i,
  input  logic [MASK_W-1:0] cpu_write_mask_i,
  input  logic              cpu_read_i,
  output logic              cpu_stall_o,
  output logic              cpu_rvalid_o,
  output logic [WORD_W-1:0] cpu_read_data_o,
  input  logic              aux_req_i,
  input  logic [WORD_W-1:0] aux_addr_i,
  input  logic [WORD_W-1:0] aux_write_data_i,
  input  logic [MASK_W-1:0] aux_write_mask_i,
  output logic              aux_gnt_o,
  output logic              aux_rvalid_o,
  output logic [WORD_W-1:0] aux_read_data_o,
  output logic [WORD_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_write_data_o,
  output logic [MASK_W-1:0] mem_write_mask_o,
  input  logic [WORD_W-1:0] mem_read_data_i
);

  // A zero threshold still needs a one-bit counter; it simply never counts.
  localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rsp_aux_q, rsp_aux_d;
  logic              rsp_cpu_q, rsp_cpu_d;
  logic              cpu_req_c;
  logic              aux_gnt_c;
  logic              cpu_stall_c;
  dmem_req_t         mem_req_c;

  // Grant, memory mux and next-state for the starvation counter / owner flags.
  always_comb begin
    cpu_req_c   = 1'b0;
    aux_gnt_c   = 1'b0;
    cpu_stall_c = 1'b0;
    mem_req_c   = '{addr: cpu_addr_i, wdata: cpu_write_data_i, mask: cpu_write_mask_i};
    wait_d      = wait_q;
    rsp_aux_d   = 1'b0;
    rsp_cpu_d   = 1'b0;

    cpu_req_c   = cpu_read_i | (|cpu_write_mask_i);
    aux_gnt_c   = aux_req_i & (~cpu_req_c | (wait_q == WAIT_MAX));
    cpu_stall_c = cpu_req_c & aux_gnt_c;

    if (aux_gnt_c) begin
      mem_req_c = '{addr: aux_addr_i, wdata: aux_write_data_i, mask: aux_write_mask_i};
    end

    if (aux_gnt_c || !aux_req_i) begin
      wait_d = '0;
    end else if (wait_q < WAIT_MAX) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    rsp_aux_d = aux_gnt_c & (aux_write_mask_i == DMEM_MASK_NONE);
    rsp_cpu_d = cpu_read_i & ~cpu_stall_c;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wait_q    <= '0;
      rsp_aux_q <= 1'b0;
      rsp_cpu_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      rsp_aux_q <= rsp_aux_d;
      rsp_cpu_q <= rsp_cpu_d;
    end
  end

  assign aux_gnt_o        = aux_gnt_c;
  assign cpu_stall_o      = cpu_stall_c;
  assign mem_addr_o       = mem_req_c.addr;
  assign mem_write_data_o = mem_req_c.wdata;
  assign mem_write_mask_o = mem_req_c.mask;

  // Read data is shared; each consumer qualifies it with its own rvalid.
  assign aux_rvalid_o     = rsp_aux_q;
  assign cpu_rvalid_o     = rsp_cpu_q;
  assign aux_read_data_o  = mem_read_data_i;
  assign cpu_read_data_o  = mem_read_data_i;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter (MAX_WAIT=4 main instance, MAX_WAIT=0 side instance).
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned MW = 4;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  word_t      cpu_addr_i, cpu_write_data_i, aux_addr_i, aux_write_data_i;
  dmem_mask_t cpu_write_mask_i, aux_write_mask_i;
  logic       cpu_read_i, aux_req_i;
  logic       cpu_stall_o, cpu_rvalid_o, aux_gnt_o, aux_rvalid_o;
  word_t      cpu_read_data_o, aux_read_data_o, mem_addr_o, mem_write_data_o;
  dmem_mask_t mem_write_mask_o;
  word_t      mem_read_data_i;

  logic       z_cpu_stall, z_cpu_rvalid, z_aux_gnt, z_aux_rvalid;
  word_t      z_cpu_rdata, z_aux_rdata, z_mem_addr, z_mem_wdata;
  dmem_mask_t z_mem_mask;

  dmem_arbiter #(.MAX_WAIT(MW)) u_dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .cpu_addr_i(cpu_addr_i), .cpu_write_data_i(cpu_write_data_i),
    .cpu_write_mask_i(cpu_write_mask_i), .cpu_read_i(cpu_read_i),
    .cpu_stall_o(cpu_stall_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_read_data_o(cpu_read_data_o),
    .aux_req_i(aux_req_i), .aux_addr_i(aux_addr_i), .aux_write_data_i(aux_write_data_i),
    .aux_write_mask_i(aux_write_mask_i), .aux_gnt_o(aux_gnt_o),
    .aux_rvalid_o(aux_rvalid_o), .aux_read_data_o(aux_read_data_o),
    .mem_addr_o(mem_addr_o), .mem_write_data_o(mem_write_data_o),
    .mem_write_mask_o(mem_write_mask_o), .mem_read_data_i(mem_read_data_i)
  );

  dmem_arbiter #(.MAX_WAIT(0)) u_dut0 (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .cpu_addr_i(cpu_addr_i), .cpu_write_data_i(cpu_write_data_i),
    .cpu_write_mask_i(cpu_write_mask_i), .cpu_read_i(cpu_read_i),
    .cpu_stall_o(z_cpu_stall), .cpu_rvalid_o(z_cpu_rvalid), .cpu_read_data_o(z_cpu_rdata),
    .aux_req_i(aux_req_i), .aux_addr_i(aux_addr_i), .aux_write_data_i(aux_write_data_i),
    .aux_write_mask_i(aux_write_mask_i), .aux_gnt_o(z_aux_gnt),
    .aux_rvalid_o(z_aux_rvalid), .aux_read_data_o(z_aux_rdata),
    .mem_addr_o(z_mem_addr), .mem_write_data_o(z_mem_wdata),
    .mem_write_mask_o(z_mem_mask), .mem_read_data_i(mem_read_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory macro: 256 words, 1-cycle read latency, byte-masked writes.
  word_t mem [256];
  word_t exp_mem [256];

  function automatic logic [7:0] idx(input word_t a);
    return 8'((a >> 2) & 32'hFF);
  endfunction

  always @(posedge clk_i) begin
    for (int b = 0; b < 4; b++)
      if (mem_write_mask_o[b]) mem[idx(mem_addr_o)][8*b +: 8] <= mem_write_data_o[8*b +: 8];
    mem_read_data_i <= mem[idx(mem_addr_o)];
  end

  // Aux master must hold its request and payload until granted.
  assert property (@(posedge clk_i) disable iff (!reset_ni)
    (aux_req_i && !aux_gnt_o) |=> (aux_req_i && $stable(aux_addr_i) &&
      $stable(aux_write_data_i) && $stable(aux_write_mask_i)))
    else $error("FAIL aux_handshake: payload changed before grant");

  typedef struct {
    logic  aux_v;
    word_t aux_d;
    logic  cpu_v;
    word_t cpu_d;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_wait = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_cpu(input logic rd, input word_t a, input word_t d, input dmem_mask_t m);
    cpu_read_i = rd; cpu_addr_i = a; cpu_write_data_i = d; cpu_write_mask_i = m;
  endtask

  task automatic drive_aux(input logic rq, input word_t a, input word_t d, input dmem_mask_t m);
    aux_req_i = rq; aux_addr_i = a; aux_write_data_i = d; aux_write_mask_i = m;
  endtask

  task automatic apply_write(input word_t a, input word_t d, input dmem_mask_t m);
    for (int b = 0; b < 4; b++)
      if (m[b]) exp_mem[idx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  // Check the combinational side of the current cycle and queue its responses.
  task automatic step_drive(output logic gnt);
    logic creq, stall;
    exp_t e;
    #1;
    creq  = cpu_read_i | (|cpu_write_mask_i);
    gnt   = aux_req_i & (!creq | (m_wait == MW));
    stall = creq & gnt;
    check_eq("aux_gnt", 32'(aux_gnt_o), 32'(gnt));
    check_eq("cpu_stall", 32'(cpu_stall_o), 32'(stall));
    check_eq("mem_addr", mem_addr_o, gnt ? aux_addr_i : cpu_addr_i);
    check_eq("mem_wdata", mem_write_data_o, gnt ? aux_write_data_i : cpu_write_data_i);
    check_eq("mem_mask", 32'(mem_write_mask_o), 32'(gnt ? aux_write_mask_i : cpu_write_mask_i));
    check_eq("mw0_aux_gnt", 32'(z_aux_gnt), 32'(aux_req_i));
    check_eq("mw0_cpu_stall", 32'(z_cpu_stall), 32'(aux_req_i & creq));
    e.aux_v = gnt && (aux_write_mask_i == DMEM_MASK_NONE);
    e.aux_d = exp_mem[idx(aux_addr_i)];
    e.cpu_v = cpu_read_i && !stall;
    e.cpu_d = exp_mem[idx(cpu_addr_i)];
    sb.push_back(e);
    if (gnt) apply_write(aux_addr_i, aux_write_data_i, aux_write_mask_i);
    else     apply_write(cpu_addr_i, cpu_write_data_i, cpu_write_mask_i);
  endtask

  // Clock the cycle, then compare the responses it should have produced.
  task automatic step_finish(input logic gnt);
    exp_t e;
    @(posedge clk_i);
    if (gnt || !aux_req_i) m_wait = 0;
    else if (m_wait < MW)  m_wait++;
    #1;
    e = sb.pop_front();
    check_eq("aux_rvalid", 32'(aux_rvalid_o), 32'(e.aux_v));
    check_eq("cpu_rvalid", 32'(cpu_rvalid_o), 32'(e.cpu_v));
    if (e.aux_v) check_eq("aux_rdata", aux_read_data_o, e.aux_d);
    if (e.cpu_v) check_eq("cpu_rdata", cpu_read_data_o, e.cpu_d);
    check_eq("wait_q", 32'(u_dut.wait_q), 32'(m_wait));
    @(negedge clk_i);
  endtask

  task automatic cyc();
    logic g;
    step_drive(g);
    step_finish(g);
  endtask

  // CPU reads every cycle while one aux read waits; aux must win after MW denials.
  task automatic starve(input word_t aux_a, input word_t cpu_base);
    logic g;
    int   denied = 0;
    logic seen = 1'b0;
    drive_aux(1'b1, aux_a, 32'h0, DMEM_MASK_NONE);
    for (int i = 0; i < 8 && !seen; i++) begin
      drive_cpu(1'b1, cpu_base + 32'(4 * i), 32'h0, DMEM_MASK_NONE);
      step_drive(g);
      seen = aux_gnt_o;
      if (!seen) denied++;
      step_finish(g);
    end
    check_eq("starve_denied", 32'(denied), 32'(MW));
    drive_aux(1'b0, 32'h0, 32'h0, DMEM_MASK_NONE);
    cyc();
    drive_cpu(1'b0, 32'h0, 32'h0, DMEM_MASK_NONE);
  endtask

  initial begin
    logic g;
    logic cpu_hold;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
      exp_mem[i] = mem[i];
    end
    mem[64] = 32'hDEAD_BEEF;
    exp_mem[64] = 32'hDEAD_BEEF;

    reset_ni = 1'b0;
    drive_cpu(1'b0, 32'h0, 32'h0, DMEM_MASK_NONE);
    drive_aux(1'b0, 32'h0, 32'h0, DMEM_MASK_NONE);
    repeat (2) @(negedge clk_i);
    #1;
    check_eq("rst_aux_rvalid", 32'(aux_rvalid_o), 32'd0);
    check_eq("rst_cpu_rvalid", 32'(cpu_rvalid_o), 32'd0);
    check_eq("rst_mem_mask", 32'(mem_write_mask_o), 32'd0);
    check_eq("rst_wait_q", 32'(u_dut.wait_q), 32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);

    // CPU-only read of the 0xDEADBEEF word
    drive_cpu(1'b1, 32'h100, 32'h0, DMEM_MASK_NONE);
    cyc();
    drive_cpu(1'b0, 32'h0, 32'h0, DMEM_MASK_NONE);

    // Aux-only full-word write; no response expected
    drive_aux(1'b1, 32'h200, 32'h1234_5678, 4'b1111);
    cyc();
    drive_aux(1'b0, 32'h0, 32'h0, DMEM_MASK_NONE);
    cyc();

    starve(32'h300, 32'h140);

    // Alternating owners on consecutive cycles
    drive_aux(1'b1, 32'h200, 32'h0, DMEM_MASK_NONE);
    cyc();
    drive_aux(1'b0, 32'h0, 32'h0, DMEM_MASK_NONE);
    drive_cpu(1'b1, 32'h100, 32'h0, DMEM_MASK_NONE);
    cyc();
    drive_cpu(1'b0, 32'h0, 32'h0, DMEM_MASK_NONE);
    drive_aux(1'b1, 32'h40C, 32'h0, DMEM_MASK_NONE);
    cyc();
    drive_aux(1'b0, 32'h0, 32'h0, DMEM_MASK_NONE);
    drive_cpu(1'b0, 32'h500, 32'hA5A5_5A5A, 4'b0011);
    cyc();
    drive_cpu(1'b1, 32'h500, 32'h0, DMEM_MASK_NONE);
    cyc();
    drive_cpu(1'b0, 32'h0, 32'h0, DMEM_MASK_NONE);

    // Reset while one aux read response is in flight and another is issued
    drive_aux(1'b1, 32'h020, 32'h0, DMEM_MASK_NONE);
    cyc();
    drive_aux(1'b1, 32'h024, 32'h0, DMEM_MASK_NONE);
    step_drive(g);
    check_eq("pre_rst_aux_rvalid", 32'(aux_rvalid_o), 32'd1);
    reset_ni = 1'b0;
    #1;
    check_eq("mid_rst_aux_rvalid", 32'(aux_rvalid_o), 32'd0);
    check_eq("mid_rst_wait_q", 32'(u_dut.wait_q), 32'd0);
    sb.delete();
    m_wait = 0;
    @(posedge clk_i);
    #1;
    check_eq("in_rst_aux_rvalid", 32'(aux_rvalid_o), 32'd0);
    @(negedge clk_i);
    drive_aux(1'b0, 32'h0, 32'h0, DMEM_MASK_NONE);
    reset_ni = 1'b1;
    @(negedge clk_i);
    #1;
    check_eq("post_rst_aux_rvalid", 32'(aux_rvalid_o), 32'd0);
    @(negedge clk_i);

    starve(32'h304, 32'h180);

    // Random legal traffic obeying the handshake and stall rules
    g = 1'b1;
    cpu_hold = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (g || !aux_req_i) begin
        if ($urandom_range(1) == 1)
          drive_aux(1'b1, 32'($urandom_range(255)) << 2, $urandom,
                    ($urandom_range(1) == 1) ? DMEM_MASK_NONE : 4'($urandom_range(15)));
        else
          drive_aux(1'b0, 32'h0, 32'h0, DMEM_MASK_NONE);
      end
      if (!cpu_hold) begin
        case ($urandom_range(2))
          0: drive_cpu(1'b0, 32'h0, 32'h0, DMEM_MASK_NONE);
          1: drive_cpu(1'b1, 32'($urandom_range(255)) << 2, 32'h0, DMEM_MASK_NONE);
          default: drive_cpu(1'b0, 32'($urandom_range(255)) << 2, $urandom,
                             4'($urandom_range(1, 15)));
        endcase
      end
      step_drive(g);
      cpu_hold = cpu_stall_o;
      step_finish(g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dmem_arbiter
